// File: rtl/redun_mont_seq.sv
// Iterative Montgomery square/multiply engine on redundant-form operands.
// One shared pipelined product unit serves the PROD, QLO and QM phases of every iteration.
module redun_mont_seq #(
  parameter int unsigned NUM_WRDS  = 4,
  parameter int unsigned WRD_BITS  = 16,
  parameter int unsigned ITER_BITS = 32,
  parameter int unsigned MUL_LAT   = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_val,
  output logic                                o_rdy,
  input  logic                                i_mode,
  input  logic [ITER_BITS-1:0]                i_iters,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_a,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_b,
  input  logic [NUM_WRDS*WRD_BITS-1:0]        i_mod,
  input  logic [NUM_WRDS*WRD_BITS-1:0]        i_mfac,
  output logic [NUM_WRDS*(WRD_BITS+1)-1:0]    o_dat,
  output logic                                o_val,
  input  logic                                i_rdy,
  output logic                                o_overflow
);

  localparam int unsigned N    = NUM_WRDS;
  localparam int unsigned W    = WRD_BITS;
  localparam int unsigned WB   = WRD_BITS + 1;
  localparam int unsigned SW   = WRD_BITS + 2;
  localparam int unsigned QW   = NUM_WRDS * WRD_BITS;
  localparam int unsigned CB   = 2 * WB + $clog2(N + 1);
  localparam int unsigned PH_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PROD = 3'd1;
  localparam logic [2:0] S_QLO  = 3'd2;
  localparam logic [2:0] S_QM   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                  state_r, state_nxt;
  logic [PH_W-1:0]             ph_r;
  logic [ITER_BITS-1:0]        iter_r;
  logic                        mode_r;
  logic [N-1:0][WB-1:0]        x_r, b_r, x_nxt;
  logic [N-1:0][W-1:0]         mod_r, mfac_r;
  logic [2*N-1:0][WB-1:0]      t_r;
  logic [QW-1:0]               q_r, q_bin;

  logic [N-1:0][WB-1:0]        op_a, op_b;
  logic [2*N-1:0][CB-1:0]      col, res_col;
  logic [2*N-1:0][SW-1:0]      s;
  logic [2*N-1:0][WB-1:0]      w;
  logic                        spill_nz, low_nz;
  logic                        accept, busy, phase_end;

  assign accept    = i_val && o_rdy;
  assign busy      = (state_r == S_PROD) || (state_r == S_QLO) || (state_r == S_QM);
  assign phase_end = busy && (ph_r == PH_W'(MUL_LAT - 1));
  assign o_dat     = x_r;

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: if (accept) state_nxt = (i_iters == '0) ? S_DONE : S_PROD;
      S_PROD: if (phase_end) state_nxt = S_QLO;
      S_QLO:  if (phase_end) state_nxt = S_QM;
      S_QM:   if (phase_end) state_nxt = (iter_r == ITER_BITS'(1)) ? S_DONE : S_PROD;
      S_DONE: if (i_rdy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Product-unit operand selection per phase
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N; i++) begin
      case (state_r)
        S_PROD: begin
          op_a[i] = x_r[i];
          op_b[i] = mode_r ? b_r[i] : x_r[i];
        end
        S_QLO: begin
          op_a[i] = t_r[i];
          op_b[i] = WB'(mfac_r[i]);
        end
        S_QM: begin
          op_a[i] = WB'(q_r[i*W +: W]);
          op_b[i] = WB'(mod_r[i]);
        end
        default: ;
      endcase
    end
  end

  // Column sums of the word products; QM folds t into the same columns
  always_comb begin
    col = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        col[i+j] = col[i+j] + CB'(op_a[i]) * CB'(op_b[j]);
    if (state_r == S_QM)
      for (int k = 0; k < 2*N; k++)
        col[k] = col[k] + CB'(t_r[k]);
  end

  generate
    if (MUL_LAT > 1) begin : g_pipe
      logic [MUL_LAT-2:0][2*N-1:0][CB-1:0] stg;
      always_ff @(posedge i_clk) begin
        stg[0] <= col;
        for (int p = 1; p < MUL_LAT - 1; p++)
          stg[p] <= stg[p-1];
      end
      assign res_col = stg[MUL_LAT-2];
    end else begin : g_nopipe
      assign res_col = col;
    end
  endgenerate

  // Two short carry passes leave every word with a single redundant bit
  always_comb begin
    for (int k = 0; k < 2*N; k++)
      s[k] = SW'(res_col[k][W-1:0]);
    for (int k = 1; k < 2*N; k++)
      s[k] = s[k] + SW'(res_col[k-1][2*W-1:W]);
    for (int k = 2; k < 2*N; k++)
      s[k] = s[k] + SW'(res_col[k-2][CB-1:2*W]);
    for (int k = 0; k < 2*N; k++)
      w[k] = WB'(s[k][W-1:0]);
    for (int k = 1; k < 2*N; k++)
      w[k] = w[k] + WB'(s[k-1][W+1:W]);
    spill_nz = (|res_col[2*N-1][CB-1:W]) | (|res_col[2*N-2][CB-1:2*W]) | (|s[2*N-1][W+1:W]);
  end

  // q is kept as its canonical residue below R so the QM result stays under 2M
  always_comb begin
    q_bin = '0;
    for (int i = 0; i < N; i++)
      q_bin = q_bin + (QW'(w[i]) << (W * i));
  end

  // Low half of t+qM is either 0 or exactly R; a nonzero word means a carry of one into the upper half
  always_comb begin
    low_nz = 1'b0;
    for (int k = 0; k < N; k++)
      low_nz = low_nz | (|w[k]);
    for (int i = 0; i < N; i++)
      x_nxt[i] = {1'b0, w[N+i][W-1:0]} + WB'((i == 0) ? low_nz : w[N+i-1][W]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= S_IDLE;
      o_rdy      <= 1'b1;
      o_val      <= 1'b0;
      o_overflow <= 1'b0;
      x_r        <= '0;
      iter_r     <= '0;
      ph_r       <= '0;
    end else begin
      state_r <= state_nxt;
      o_rdy   <= (state_nxt == S_IDLE);
      o_val   <= (state_nxt == S_DONE);
      ph_r    <= (busy && !phase_end) ? ph_r + PH_W'(1) : '0;
      if (accept) begin
        mode_r     <= i_mode;
        iter_r     <= i_iters;
        x_r        <= i_a;
        b_r        <= i_b;
        mod_r      <= i_mod;
        mfac_r     <= i_mfac;
        o_overflow <= 1'b0;
      end
      if (phase_end) begin
        case (state_r)
          S_PROD: begin
            t_r <= w;
            if (spill_nz) o_overflow <= 1'b1;
          end
          S_QLO: q_r <= q_bin;
          S_QM: begin
            x_r    <= x_nxt;
            iter_r <= iter_r - ITER_BITS'(1);
            if (spill_nz || w[2*N-1][W]) o_overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_redun_mont_seq.sv
// Directed and soak bench for redun_mont_seq against a wide-integer Montgomery model.
module tb_redun_mont_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned WB = 17;
  localparam int unsigned ML = 2;

  logic          clk = 1'b0;
  logic          rst, val, rdy_o, mode, oval, irdy, ovf;
  logic [31:0]   iters;
  logic [67:0]   a, b, dat;
  logic [63:0]   md, mf;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  redun_mont_seq #(.NUM_WRDS(N), .WRD_BITS(W), .ITER_BITS(32), .MUL_LAT(ML)) dut (
    .i_clk(clk), .i_rst(rst), .i_val(val), .o_rdy(rdy_o), .i_mode(mode),
    .i_iters(iters), .i_a(a), .i_b(b), .i_mod(md), .i_mfac(mf),
    .o_dat(dat), .o_val(oval), .i_rdy(irdy), .o_overflow(ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] val_of(input logic [67:0] d);
    logic [127:0] v = '0;
    for (int i = 0; i < N; i++) v = v + (128'(d[i*WB +: WB]) << (W * i));
    return v;
  endfunction

  function automatic logic [63:0] neg_inv(input logic [63:0] m);
    logic [63:0] inv = m;
    repeat (6) inv = inv * (64'd2 - m * inv);
    return 64'd0 - inv;
  endfunction

  function automatic logic [127:0] mont(input logic [127:0] x, input logic [127:0] y,
                                        input logic [63:0] m, input logic [63:0] mfac);
    logic [255:0] t, r;
    logic [63:0]  q;
    t = 256'(x) * 256'(y);
    q = t[63:0] * mfac;
    r = (t + 256'(q) * 256'(m)) >> 64;
    return r[127:0];
  endfunction

  function automatic logic [127:0] model(input logic m, input int t, input logic [127:0] av,
                                         input logic [127:0] bv, input logic [63:0] mm, input logic [63:0] mff);
    logic [127:0] x = av;
    repeat (t) x = mont(x, m ? bv : x, mm, mff);
    return x;
  endfunction

  // Redundant encoding of a value below 2^65, optionally with random borrows between words
  function automatic logic [67:0] enc(input logic [127:0] v, input bit redund);
    logic [16:0] wd [4];
    logic [67:0] d;
    for (int i = 0; i < 3; i++) wd[i] = {1'b0, v[16*i +: 16]};
    wd[3] = v[64:48];
    if (redund)
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 1) == 1 && wd[i+1] != 17'd0) begin
          wd[i+1] = wd[i+1] - 17'd1;
          wd[i]   = wd[i] + 17'h10000;
        end
    for (int i = 0; i < 4; i++) d[i*WB +: WB] = wd[i];
    return d;
  endfunction

  task automatic run_job(input string tag, input logic m, input int t, input logic [67:0] aa,
                         input logic [67:0] bb, input logic [63:0] mm, input logic [63:0] mff,
                         input int stall, output logic [67:0] res, output logic ov);
    int guard = 0;
    int lat;
    while (!rdy_o && guard < 1000) begin tick; guard++; end
    check({tag, "_rdy"}, 128'(rdy_o), 128'(1));
    val = 1'b1; mode = m; iters = t; a = aa; b = bb; md = mm; mf = mff;
    tick;
    val = 1'b0;
    a = 68'({$urandom, $urandom, $urandom}); b = 68'({$urandom, $urandom, $urandom});
    md = {$urandom, $urandom}; mf = {$urandom, $urandom}; mode = ~m; iters = $urandom;
    check({tag, "_busy"}, 128'({rdy_o, ovf}), 128'(0));
    lat = 1;
    while (!oval && lat < 3*ML*t + 50) begin
      val = 1'($urandom_range(0, 1));
      tick;
      lat++;
    end
    val = 1'b0;
    check({tag, "_lat"}, 128'(lat), 128'(1 + 3*ML*t));
    res = dat;
    ov  = ovf;
    for (int k = 0; k < stall; k++) begin
      tick;
      check({tag, "_hold"}, 128'({oval, ovf, dat}), 128'({1'b1, ov, res}));
    end
    irdy = 1'b1;
    tick;
    irdy = 1'b0;
    check({tag, "_drain"}, 128'({oval, rdy_o}), 128'(2'b01));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  m1, mf1, m2, mf2;
    logic [67:0]  res, aa, bb;
    logic [127:0] v, av, bv, e;
    logic         ov, saw;
    logic         rm;
    int           rt;

    m1  = 64'h3FFF_FFFF_FFFF_FFC7;
    mf1 = neg_inv(m1);
    m2  = 64'hFFFF_FFFF_FFFF_FFC5;
    mf2 = neg_inv(m2);

    rst = 1'b1; val = 1'b0; irdy = 1'b0; mode = 1'b0; iters = '0;
    a = '0; b = '0; md = '0; mf = '0;
    tick; tick;
    check("rst_rdy", 128'(rdy_o), 128'(1));
    check("rst_val", 128'(oval), 128'(0));
    check("rst_ovf", 128'(ovf), 128'(0));
    check("rst_dat", 128'(dat), 128'(0));
    rst = 1'b0;
    tick;

    // Montgomery one: R mod M = 4*57 = 228 is a fixed point of squaring
    run_job("one", 1'b0, 5, enc(128'd228, 1'b0), '0, m1, mf1, 2, res, ov);
    v = val_of(res);
    check("one_model", v, model(1'b0, 5, 128'd228, '0, m1, mf1));
    check("one_set", 128'(v == 128'd228 || v == 128'd228 + 128'(m1)), 128'(1));
    check("one_ovf", 128'(ov), 128'(0));

    run_job("zero", 1'b0, 100, enc(128'd0, 1'b0), '0, m1, mf1, 0, res, ov);
    check("zero_val", val_of(res), 128'd0);

    aa = enc(128'd12345, 1'b1);
    run_job("pass", 1'b1, 0, aa, enc(128'd77, 1'b0), m1, mf1, 1, res, ov);
    check("pass_dat", 128'(res), 128'(aa));

    bv = 128'h0123_4567_89AB_CDEF;
    run_job("mul", 1'b1, 1, enc(128'd228, 1'b0), enc(bv, 1'b1), m1, mf1, 3, res, ov);
    v = val_of(res);
    check("mul_cong", v % 128'(m1), bv);
    check("mul_model", v, model(1'b1, 1, 128'd228, bv, m1, mf1));

    // Reset in the middle of a T=10 job
    val = 1'b1; mode = 1'b0; iters = 10; a = enc(128'd5000, 1'b0); md = m1; mf = mf1;
    tick;
    val = 1'b0;
    saw = 1'b0;
    repeat (6) begin tick; saw = saw | oval; end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_rdy", 128'({rdy_o, oval}), 128'(2'b10));
    repeat (70) begin tick; saw = saw | oval; end
    check("mid_no_val", 128'(saw), 128'(0));
    check("mid_idle", 128'(rdy_o), 128'(1));
    av = 128'd987654321;
    run_job("after", 1'b0, 3, enc(av, 1'b1), '0, m1, mf1, 0, res, ov);
    check("after_model", val_of(res), model(1'b0, 3, av, '0, m1, mf1));

    // Modulus above the R/4 bound with a = 2M-1 must flag overflow
    av = 128'(m2) * 128'd2 - 128'd1;
    run_job("ovf", 1'b0, 1, enc(av, 1'b0), '0, m2, mf2, 1, res, ov);
    check("ovf_set", 128'(ov), 128'(1));
    run_job("ovf_next", 1'b0, 1, enc(128'd228, 1'b0), '0, m1, mf1, 0, res, ov);
    check("ovf_clear", 128'(ov), 128'(0));

    for (int j = 0; j < 40; j++) begin
      rm = 1'($urandom_range(0, 1));
      rt = $urandom_range(0, 12);
      av = 128'({$urandom, $urandom}) % (128'(m1) * 128'd2);
      bv = 128'({$urandom, $urandom}) % (128'(m1) * 128'd2);
      run_job($sformatf("soak%0d", j), rm, rt, enc(av, 1'b1), enc(bv, 1'b1), m1, mf1,
              $urandom_range(0, 3), res, ov);
      v = val_of(res);
      e = model(rm, rt, av, bv, m1, mf1);
      check($sformatf("soak%0d_model", j), v, e);
      check($sformatf("soak%0d_bound", j), 128'({ov, v < 128'(m1) * 128'd2}), 128'(2'b01));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
